// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: instruction field positions, default opcode
// masks and a few named opcodes.
package decode_pkg;

   localparam int unsigned RD_LSB = 7;
   localparam int unsigned RA_LSB = 15;
   localparam int unsigned RB_LSB = 20;

   localparam logic [15:0] DEF_WB_MASK = 16'hFFF0;
   localparam logic [15:0] DEF_RB_MASK = 16'h00F0;

   localparam logic [3:0] OP_BRANCH = 4'h0;
   localparam logic [3:0] OP_STORE  = 4'h1;
   localparam logic [3:0] OP_JUMP   = 4'h2;
   localparam logic [3:0] OP_SYS    = 4'h3;
   localparam logic [3:0] OP_ALU_RR = 4'h4;
   localparam logic [3:0] OP_ALU_RI = 4'h8;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register. Bits are set by issuing writers and cleared by
// writeback; the read ports see a same-cycle writeback as already retired.
module reg_scoreboard #(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_en,
   input  logic [REG_W-1:0] set_reg,
   input  logic             clr_en,
   input  logic [REG_W-1:0] clr_reg,
   input  logic [REG_W-1:0] rd_a,
   input  logic [REG_W-1:0] rd_b,
   output logic             busy_a,
   output logic             busy_b
);

   localparam int unsigned NUM_REGS = 2 ** REG_W;

   logic [NUM_REGS-1:0] busy_q, busy_d;

   // Set is applied after clear so a new writer wins over a retiring one.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_reg] = 1'b0;
      if (set_en) busy_d[set_reg] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_a = busy_q[rd_a] && !(clr_en && (clr_reg == rd_a));
   assign busy_b = busy_q[rd_b] && !(clr_en && (clr_reg == rd_b));

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode with a RAW-hazard scoreboard, valid/ready handshakes on
// both sides and a branch flush.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned OPC_W = 4,
   parameter int unsigned REG_W = 5,
   parameter int unsigned OFF_W = 13,
   parameter logic [2**OPC_W-1:0] WB_MASK = DEF_WB_MASK,
   parameter logic [2**OPC_W-1:0] RB_MASK = DEF_RB_MASK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  instruction,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OPC_W-1:0] opcode,
   output logic [REG_W-1:0] reg_d,
   output logic [REG_W-1:0] reg_a,
   output logic [REG_W-1:0] reg_b,
   output logic [XLEN-1:0]  offset,
   output logic             writes_rd,
   output logic [XLEN-1:0]  out_pc,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_reg,
   output logic [31:0]      stall_count
);

   logic             held_valid_q, held_valid_d;
   logic [OPC_W-1:0] opcode_q;
   logic [REG_W-1:0] rd_q, ra_q, rb_q;
   logic [OFF_W-1:0] off_q;
   logic [XLEN-1:0]  pc_q;
   logic [31:0]      stall_q, stall_d;
   logic             busy_a, busy_b, hazard, issue, accept;
   logic             unused_instr;

   assign unused_instr = ^instruction;

   assign opcode    = opcode_q;
   assign reg_d     = rd_q;
   assign reg_a     = ra_q;
   assign reg_b     = rb_q;
   assign offset    = {{(XLEN - OFF_W){off_q[OFF_W-1]}}, off_q};
   assign out_pc    = pc_q;
   assign writes_rd = WB_MASK[opcode_q] && (rd_q != '0);

   assign hazard      = busy_a || (RB_MASK[opcode_q] && busy_b);
   assign out_valid   = held_valid_q && !hazard;
   assign issue       = out_valid && out_ready;
   assign in_ready    = !flush && (!held_valid_q || issue);
   assign accept      = in_valid && in_ready;
   assign stall_count = stall_q;

   // Flush empties the slot but a coincident issue still reaches the scoreboard.
   always_comb begin
      held_valid_d = held_valid_q;
      if (flush)       held_valid_d = 1'b0;
      else if (accept) held_valid_d = 1'b1;
      else if (issue)  held_valid_d = 1'b0;

      stall_d = stall_q;
      if (held_valid_q && hazard && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_valid_q <= 1'b0;
         opcode_q     <= '0;
         rd_q         <= '0;
         ra_q         <= '0;
         rb_q         <= '0;
         off_q        <= '0;
         pc_q         <= '0;
         stall_q      <= '0;
      end else begin
         held_valid_q <= held_valid_d;
         stall_q      <= stall_d;
         if (accept) begin
            opcode_q <= instruction[OPC_W-1:0];
            rd_q     <= instruction[RD_LSB +: REG_W];
            ra_q     <= instruction[RA_LSB +: REG_W];
            rb_q     <= instruction[RB_LSB +: REG_W];
            off_q    <= instruction[XLEN-1 -: OFF_W];
            pc_q     <= in_pc;
         end
      end
   end

   reg_scoreboard #(
      .REG_W(REG_W)
   ) u_scoreboard (
      .clk    (clk),
      .rst_n  (rst_n),
      .set_en (issue && writes_rd),
      .set_reg(rd_q),
      .clr_en (wb_valid),
      .clr_reg(wb_reg),
      .rd_a   (ra_q),
      .rd_b   (rb_q),
      .busy_a (busy_a),
      .busy_b (busy_b)
   );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic, all
// checked cycle by cycle against a behavioural model of the decode slot and scoreboard.
module tb_decode_stage;
   import decode_pkg::*;

   // Default write mask plus opcode 3, so the x3 writer scenario actually writes.
   localparam logic [15:0] TB_WB_MASK = DEF_WB_MASK | 16'h0008;
   localparam logic [15:0] TB_RB_MASK = DEF_RB_MASK;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  opcode;
   logic [4:0]  reg_d, reg_a, reg_b;
   logic [31:0] offset;
   logic        writes_rd;
   logic [31:0] out_pc;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_reg = '0;
   logic [31:0] stall_count;

   decode_stage #(
      .WB_MASK(TB_WB_MASK),
      .RB_MASK(TB_RB_MASK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instruction(instruction),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .opcode     (opcode),
      .reg_d      (reg_d),
      .reg_a      (reg_a),
      .reg_b      (reg_b),
      .offset     (offset),
      .writes_rd  (writes_rd),
      .out_pc     (out_pc),
      .wb_valid   (wb_valid),
      .wb_reg     (wb_reg),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one held instruction word, a busy flag per register, a stall count.
   bit          m_held;
   bit   [31:0] m_instr, m_pc, m_stall;
   bit          m_busy[32];

   function automatic int unsigned f_op(bit [31:0] w); return w & 32'hF;         endfunction
   function automatic int unsigned f_rd(bit [31:0] w); return (w >> 7) & 32'h1F;  endfunction
   function automatic int unsigned f_ra(bit [31:0] w); return (w >> 15) & 32'h1F; endfunction
   function automatic int unsigned f_rb(bit [31:0] w); return (w >> 20) & 32'h1F; endfunction

   function automatic bit m_busy_eff(int unsigned r, bit wv, int unsigned wr);
      return (r != 0) && m_busy[r] && !(wv && (wr == r));
   endfunction

   function automatic bit [31:0] m_busy_vec();
      bit [31:0] v = '0;
      for (int r = 0; r < 32; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic model_reset();
      m_held = 0; m_instr = '0; m_pc = '0; m_stall = '0;
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
   endtask

   task automatic cycle(input bit iv, input bit [31:0] ins, input bit [31:0] pc, input bit ordy,
                        input bit wv, input bit [4:0] wr, input bit fl);
      bit          hz, ov, ir, wr_en, iss;
      bit   [31:0] exp_off;
      @(negedge clk);
      in_valid = iv; instruction = ins; in_pc = pc; out_ready = ordy;
      wb_valid = wv; wb_reg = wr; flush = fl;
      #1;
      hz = m_held && (m_busy_eff(f_ra(m_instr), wv, wr) ||
                      (TB_RB_MASK[f_op(m_instr)] && m_busy_eff(f_rb(m_instr), wv, wr)));
      ov = m_held && !hz;
      ir = !fl && (!m_held || (ov && ordy));
      wr_en = TB_WB_MASK[f_op(m_instr)] && (f_rd(m_instr) != 0);
      exp_off = $signed(m_instr) >>> 19;
      check("out_valid", {31'd0, out_valid}, {31'd0, ov});
      check("in_ready", {31'd0, in_ready}, {31'd0, ir});
      check("opcode", {28'd0, opcode}, f_op(m_instr));
      check("reg_d", {27'd0, reg_d}, f_rd(m_instr));
      check("reg_a", {27'd0, reg_a}, f_ra(m_instr));
      check("reg_b", {27'd0, reg_b}, f_rb(m_instr));
      check("offset", offset, exp_off);
      check("writes_rd", {31'd0, writes_rd}, {31'd0, wr_en});
      check("out_pc", out_pc, m_pc);
      check("stall_count", stall_count, m_stall);
      check("busy", dut.u_scoreboard.busy_q, m_busy_vec());
      @(posedge clk);
      iss = ov && ordy;
      if (wv && wr != 0) m_busy[wr] = 0;
      if (iss && wr_en) m_busy[f_rd(m_instr)] = 1;
      if (hz && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (ir && iv) begin m_instr = ins; m_pc = pc; end
      if (fl) m_held = 0;
      else if (ir && iv) m_held = 1;
      else if (iss) m_held = 0;
   endtask

   task automatic idle_inputs();
      in_valid = 0; out_ready = 0; wb_valid = 0; wb_reg = '0; flush = 0;
   endtask

   task automatic reset_mid_cycle();
      @(negedge clk);
      idle_inputs();
      #2 rst_n = 0;
      #1;
      model_reset();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_stall", stall_count, 32'd0);
      check("rst_busy", dut.u_scoreboard.busy_q, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   function automatic bit [31:0] rand_instr();
      bit [31:0] w = $urandom;
      w[11:7]  = 5'($urandom_range(0, 4));
      w[19:15] = 5'($urandom_range(0, 4));
      w[24:20] = 5'($urandom_range(0, 4));
      return w;
   endfunction

   initial begin
      model_reset();
      #1;
      check("init_out_valid", {31'd0, out_valid}, 32'd0);
      check("init_in_ready", {31'd0, in_ready}, 32'd1);
      check("init_stall", stall_count, 32'd0);
      @(negedge clk);
      rst_n = 1;

      // Writer to x3 decodes and marks x3 busy on issue.
      cycle(1, 32'h0030_8193, 32'h100, 1, 0, 0, 0);
      #1;
      check("t2_opcode", {28'd0, opcode}, 32'd3);
      check("t2_reg_d", {27'd0, reg_d}, 32'd3);
      check("t2_reg_a", {27'd0, reg_a}, 32'd1);
      check("t2_reg_b", {27'd0, reg_b}, 32'd3);
      check("t2_out_valid", {31'd0, out_valid}, 32'd1);
      cycle(0, 0, 0, 1, 0, 0, 0);
      #1;
      check("t2_busy3", {31'd0, dut.u_scoreboard.busy_q[3]}, 32'd1);

      // Reader of x3 stalls until writeback, which releases it in the same cycle.
      cycle(1, 32'h0001_8000, 32'h104, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0, 0);
      #1;
      check("t3_stall_count", stall_count, 32'd4);
      check("t3_stalled", {31'd0, out_valid}, 32'd0);
      cycle(0, 0, 0, 1, 1, 5'd3, 0);

      // Offset sign extension at both extremes.
      cycle(1, {13'h1FFF, 19'h0}, 32'h108, 1, 0, 0, 0);
      #1;
      check("t4_offset_neg", offset, 32'hFFFF_FFFF);
      cycle(1, {13'h0FFF, 19'h0}, 32'h10C, 1, 0, 0, 0);
      #1;
      check("t4_offset_pos", offset, 32'h0000_0FFF);
      cycle(0, 0, 0, 1, 0, 0, 0);

      // Backpressure: 5 cycles of out_ready=0 with fetch still offering.
      cycle(1, 32'h0000_0A85, 32'h200, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 32'h0000_0B86, 32'h204, 0, 0, 0, 0);
      #1;
      check("t5_held_pc", out_pc, 32'h200);
      cycle(1, 32'h0000_0B86, 32'h204, 1, 0, 0, 0);
      #1;
      check("t5_next_pc", out_pc, 32'h204);
      cycle(0, 0, 0, 1, 0, 0, 0);
      for (int r = 1; r < 32; r++) cycle(0, 0, 0, 0, 1, 5'(r), 0);

      // Flush while stalled on x5: slot empties, busy[5] survives, offered word dropped.
      cycle(1, {24'h0, 1'b1, 3'b010, OP_ALU_RR} | 32'h280, 32'h300, 1, 0, 0, 0);
      cycle(1, 32'h0002_8000, 32'h304, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(1, 32'h0000_0000, 32'h308, 1, 0, 0, 1);
      #1;
      check("t6_out_valid", {31'd0, out_valid}, 32'd0);
      check("t6_busy5", {31'd0, dut.u_scoreboard.busy_q[5]}, 32'd1);
      check("t6_pc_kept", out_pc, 32'h304);
      cycle(0, 0, 0, 1, 1, 5'd5, 0);

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 4)), $urandom_range(0, 15) == 0);
      end

      // Reset while a reader is stalled.
      for (int r = 1; r < 32; r++) cycle(0, 0, 0, 1, 1, 5'(r), 0);
      cycle(1, 32'h0030_8193, 32'h400, 1, 0, 0, 0);
      cycle(1, 32'h0001_8000, 32'h404, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      reset_mid_cycle();
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, 5'($urandom_range(0, 4)), $urandom_range(0, 15) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
